add_mult_reducer: RTL and testbench

ADD_MULT_REDUCER -- requirements
Module: add_mult_reducer

---
 rtl/add_mult_reducer_if.sv | 30 +++
 rtl/add_mult_reducer.sv | 90 +++++++++
 tb/tb_add_mult_reducer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/add_mult_reducer_if.sv
// Beat-in / result-out bus for the add_mult_reducer block.
// The producer uses the master modport and the reducer uses the slave modport.
interface add_mult_reducer_if #(
    parameter int IN_SIZE_1 = 8,
    parameter int ACC_SIZE  = 32,
    parameter int LEN_SIZE  = 8
);
    localparam int PP_W = (IN_SIZE_1 + 1) * 2;

    logic                       valid_i;
    logic                       ready_o;
    logic [0:11][PP_W-1:0]      pp_i;
    logic signed [ACC_SIZE-1:0] corr_i;
    logic                       last_i;
    logic                       res_valid_o;
    logic                       res_ready_i;
    logic signed [ACC_SIZE-1:0] res_o;
    logic [LEN_SIZE-1:0]        res_cnt_o;
    logic                       ovf_o;

    modport slave (
        input  valid_i, pp_i, corr_i, last_i, res_ready_i,
        output ready_o, res_valid_o, res_o, res_cnt_o, ovf_o
    );

    modport master (
        output valid_i, pp_i, corr_i, last_i, res_ready_i,
        input  ready_o, res_valid_o, res_o, res_cnt_o, ovf_o
    );
endinterface

// File: rtl/add_mult_reducer.sv
// Reduces twelve partial terms per beat into a signed dot-product accumulator.
// The design has two pipeline stages, a beat counter, and a sticky overflow flag.
module add_mult_reducer #(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int ACC_SIZE  = 32,
    parameter int LEN_SIZE  = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    add_mult_reducer_if.slave bus
);
    if (IN_SIZE_0 < 1 || IN_SIZE_1 < 1 || ACC_SIZE < 2 || LEN_SIZE < 1) begin : g_bad_cfg
        $error("add_mult_reducer: invalid parameter set");
    end

    localparam int                  MSB     = ACC_SIZE - 1;
    localparam logic [LEN_SIZE-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                     state, state_nxt;
    logic                       ready, res_valid, xfer;
    logic                       s1_vld, ovf, add_ovf;
    logic signed [ACC_SIZE-1:0] beat, s1, acc, sum2;
    logic [LEN_SIZE-1:0]        cnt;

    assign ready = rst_ni && (state == IDLE || state == RUN);
    assign xfer  = bus.valid_i && ready;

    // The four products P0..P3 are folded into one flat sum of all twelve terms.
    always_comb begin
        beat = -bus.corr_i;
        for (int k = 0; k < 12; k++)
            beat = beat + ACC_SIZE'($signed(bus.pp_i[k]));
    end

    assign sum2    = acc + s1;
    assign add_ovf = s1_vld && (acc[MSB] == s1[MSB]) && (sum2[MSB] != acc[MSB]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        res_valid = 1'b0;
        case (state)
            IDLE, RUN: if (xfer) state_nxt = bus.last_i ? DRAIN : RUN;
            DRAIN:     state_nxt = OUT;
            OUT: begin
                res_valid = 1'b1;
                if (bus.res_ready_i) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1     <= '0;
            s1_vld <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (state == OUT && bus.res_ready_i) begin
            s1_vld <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            s1_vld <= xfer;
            if (s1_vld) acc <= sum2;
            if (add_ovf) ovf <= 1'b1;
            if (xfer) begin
                s1 <= beat;
                // A counter that is already saturated reports overflow rather than wrapping.
                if (cnt == CNT_MAX) ovf <= 1'b1;
                else                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.ready_o     = ready;
    assign bus.res_valid_o = res_valid;
    assign bus.res_o       = acc;
    assign bus.res_cnt_o   = cnt;
    assign bus.ovf_o       = ovf;
endmodule

// File: tb/tb_add_mult_reducer.sv
// Self-checking bench for add_mult_reducer.
// It applies directed and random beats and compares results against an exact-arithmetic model.
module tb_add_mult_reducer;
    localparam int PP_W = 18;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    int   m_acc;
    int   m_cnt;
    bit   m_ovf;

    logic [0:11][PP_W-1:0] pp;

    add_mult_reducer_if #(.IN_SIZE_1(8), .ACC_SIZE(32), .LEN_SIZE(8)) bus ();

    add_mult_reducer #(.IN_SIZE_0(4), .IN_SIZE_1(8), .ACC_SIZE(32), .LEN_SIZE(8)) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    // The model uses exact wide arithmetic and flags an overflow when the true sum leaves the 32-bit range.
    task automatic beat(input logic [0:11][PP_W-1:0] p, input logic [31:0] corr, input bit last);
        longint s, t;
        int     b;
        @(negedge clk);
        bus.pp_i    = p;
        bus.corr_i  = corr;
        bus.last_i  = last;
        bus.valid_i = 1'b1;
        chk("beat_ready", {31'd0, bus.ready_o}, 32'd1);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        s = 0;
        for (int k = 0; k < 12; k++) s += longint'($signed(p[k]));
        s -= longint'($signed(corr));
        b = int'(s);
        t = longint'(m_acc) + longint'(b);
        if (t > 64'sd2147483647 || t < -64'sd2147483648) m_ovf = 1;
        m_acc = int'(t);
        if (m_cnt == 255) m_ovf = 1;
        else              m_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The caller must invoke this right after the last-beat edge (that edge plus one time unit).
    task automatic result(input string tag, input int hold);
        @(negedge clk);
        chk({tag, "_drain_valid"}, {31'd0, bus.res_valid_o}, 32'd0);
        chk({tag, "_drain_ready"}, {31'd0, bus.ready_o}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, bus.res_valid_o}, 32'd1);
        chk({tag, "_res"}, bus.res_o, m_acc);
        chk({tag, "_cnt"}, {24'd0, bus.res_cnt_o}, m_cnt);
        chk({tag, "_ovf"}, {31'd0, bus.ovf_o}, {31'd0, m_ovf});
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag, "_hold_res"}, bus.res_o, m_acc);
            chk({tag, "_hold_cnt"}, {24'd0, bus.res_cnt_o}, m_cnt);
            chk({tag, "_hold_valid"}, {31'd0, bus.res_valid_o}, 32'd1);
            chk({tag, "_hold_ready"}, {31'd0, bus.ready_o}, 32'd0);
        end
        bus.res_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.res_ready_i = 1'b0;
        model_clear();
        chk({tag, "_clr_valid"}, {31'd0, bus.res_valid_o}, 32'd0);
        chk({tag, "_clr_ready"}, {31'd0, bus.ready_o}, 32'd1);
        chk({tag, "_clr_res"}, bus.res_o, 32'd0);
        chk({tag, "_clr_cnt"}, {24'd0, bus.res_cnt_o}, 32'd0);
        chk({tag, "_clr_ovf"}, {31'd0, bus.ovf_o}, 32'd0);
    endtask

    initial begin
        int len, hold;
        logic [31:0] corr;
        rst_n           = 1'b0;
        bus.valid_i     = 1'b0;
        bus.pp_i        = '0;
        bus.corr_i      = '0;
        bus.last_i      = 1'b0;
        bus.res_ready_i = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.res_valid_o}, 32'd0);
        chk("rst_res", bus.res_o, 32'd0);
        chk("rst_cnt", {24'd0, bus.res_cnt_o}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat: 5 + 7 - 2 = 10
        pp = '0; pp[0] = 18'd5; pp[3] = 18'd7;
        beat(pp, 32'd2, 1'b1);
        chk("single_model", m_acc, 32'd10);
        result("single", 0);

        // Three beats of (12 - 4): total 24
        for (int k = 0; k < 12; k++) pp[k] = 18'd1;
        beat(pp, 32'd4, 1'b0);
        beat(pp, 32'd4, 1'b0);
        beat(pp, 32'd4, 1'b1);
        chk("three_model", m_acc, 32'd24);
        result("three", 0);

        // Negative terms: -9 - (-1) = -8
        pp = '0; pp[0] = -18'sd3; pp[1] = -18'sd3; pp[2] = -18'sd3;
        beat(pp, -32'sd1, 1'b1);
        chk("neg_model", m_acc, -32'sd8);
        result("neg", 0);

        // Backpressure for 10 cycles, then a beat immediately after the handshake
        pp = '0; pp[5] = 18'd100;
        beat(pp, 32'd0, 1'b0);
        idle(2);
        beat(pp, 32'd1, 1'b1);
        result("bp", 10);
        pp = '0; pp[11] = 18'd3;
        beat(pp, 32'd0, 1'b1);
        chk("fresh_model", m_acc, 32'd3);
        result("fresh", 0);

        // Signed overflow: the sum 0x7000_0000 + 0x7000_0000 wraps to 0xE000_0000
        pp = '0;
        beat(pp, 32'h9000_0000, 1'b0);
        beat(pp, 32'h9000_0000, 1'b1);
        chk("ovf_model", m_acc, 32'hE000_0000);
        result("ovf", 2);

        // Counter saturation after 256 beats
        for (int i = 0; i < 256; i++) beat(pp, 32'd0, i == 255);
        chk("sat_model", m_cnt, 32'd255);
        result("sat", 0);

        // Reset mid-accumulation discards the pending result
        pp = '0; pp[0] = 18'd40;
        beat(pp, 32'd0, 1'b0);
        beat(pp, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 model_clear();
        @(negedge clk);
        chk("mrst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("mrst_res", bus.res_o, 32'd0);
        chk("mrst_cnt", {24'd0, bus.res_cnt_o}, 32'd0);
        chk("mrst_valid", {31'd0, bus.res_valid_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pp = '0; pp[4] = 18'd9;
        beat(pp, 32'd0, 1'b1);
        result("post_rst", 0);

        // Random sequences with idle gaps and backpressure
        for (int s = 0; s < 12; s++) begin
            len  = $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            for (int b = 0; b < len; b++) begin
                for (int k = 0; k < 12; k++) pp[k] = PP_W'($urandom);
                corr = (s % 3 == 0) ? $urandom : $urandom_range(0, 4000) - 2000;
                beat(pp, corr, b == len - 1);
                if (b != len - 1) idle($urandom_range(0, 2));
            end
            result("rand", hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
